// File: rtl/memory_board_pkg.sv
// rtl/memory_board_pkg.sv - shared cell and board-state types for the memory game controller
package memory_board_pkg;

  typedef enum logic [1:0] {
    HIDDEN   = 2'b00,
    REVEALED = 2'b01,
    MATCHED  = 2'b10
  } cell_state_t;

  typedef enum logic [1:0] {
    PICK1,
    PICK2,
    SHOW,
    DONE
  } board_fsm_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-cycle event on the rising edge of a synchronous button level
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic pulse_o
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= level_i;
  end

  // Combinational so the event is consumed at the first edge that samples the level high.
  assign pulse_o = level_i & ~prev;

endmodule

// File: rtl/memory_board_ctrl.sv
// rtl/memory_board_ctrl.sv - cursor, card reveal and pair resolution for the card-matching board
module memory_board_ctrl
  import memory_board_pkg::*;
#(
  parameter int NUM_CELLS   = 16,
  parameter int CARD_W      = 4,
  parameter int SHOW_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 move,
  input  logic                                 select,
  input  logic [NUM_CELLS*CARD_W-1:0]          card_i,
  output logic [$clog2(NUM_CELLS)-1:0]         cursor_o,
  output logic [2*NUM_CELLS-1:0]               cell_state_o,
  output logic [$clog2(NUM_CELLS/2+1)-1:0]     pairs_o,
  output logic [CNT_W-1:0]                     attempts_o,
  output logic                                 match_o,
  output logic                                 miss_o,
  output logic                                 done_o
);

  localparam int CW   = $clog2(NUM_CELLS);
  localparam int PW   = $clog2(NUM_CELLS/2+1);
  localparam int TW   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int HALF = NUM_CELLS / 2;

  generate
    if ((NUM_CELLS % 2) != 0 || NUM_CELLS < 2 || SHOW_CYCLES < 1) begin : g_bad_params
      $error("memory_board_ctrl: NUM_CELLS must be even and >= 2, SHOW_CYCLES >= 1");
    end
  endgenerate

  logic          move_ev;
  logic          select_ev;
  board_fsm_t    state;
  logic [CW-1:0] idx1;
  logic [CW-1:0] idx2;
  logic          eq;
  logic [TW-1:0] timer;

  logic              cur_hidden;
  logic [CARD_W-1:0] card_first;
  logic [CARD_W-1:0] card_cur;

  rise_detect u_move_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (move),
    .pulse_o (move_ev)
  );

  rise_detect u_select_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (select),
    .pulse_o (select_ev)
  );

  assign cur_hidden = (cell_state_o[2*cursor_o +: 2] == HIDDEN);
  assign card_first = card_i[idx1*CARD_W +: CARD_W];
  assign card_cur   = card_i[cursor_o*CARD_W +: CARD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PICK1;
      cursor_o     <= '0;
      cell_state_o <= '0;
      pairs_o      <= '0;
      attempts_o   <= '0;
      match_o      <= 1'b0;
      miss_o       <= 1'b0;
      done_o       <= 1'b0;
      idx1         <= '0;
      idx2         <= '0;
      eq           <= 1'b0;
      timer        <= '0;
    end else begin
      match_o <= 1'b0;
      miss_o  <= 1'b0;

      case (state)
        PICK1: begin
          if (select_ev && cur_hidden) begin
            cell_state_o[2*cursor_o +: 2] <= REVEALED;
            idx1  <= cursor_o;
            state <= PICK2;
          end
        end
        PICK2: begin
          // idx1 is already REVEALED, so re-selecting it falls out of the hidden test.
          if (select_ev && cur_hidden) begin
            cell_state_o[2*cursor_o +: 2] <= REVEALED;
            idx2  <= cursor_o;
            eq    <= (card_first == card_cur);
            timer <= TW'(SHOW_CYCLES - 1);
            if (attempts_o != {CNT_W{1'b1}}) attempts_o <= attempts_o + 1'b1;
            state <= SHOW;
          end
        end
        SHOW: begin
          if (timer == '0) begin
            if (eq) begin
              cell_state_o[2*idx1 +: 2] <= MATCHED;
              cell_state_o[2*idx2 +: 2] <= MATCHED;
              pairs_o <= pairs_o + 1'b1;
              match_o <= 1'b1;
              if (pairs_o == PW'(HALF - 1)) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state <= PICK1;
              end
            end else begin
              cell_state_o[2*idx1 +: 2] <= HIDDEN;
              cell_state_o[2*idx2 +: 2] <= HIDDEN;
              miss_o <= 1'b1;
              state  <= PICK1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
        end
      endcase

      // Select above used the pre-move cursor; the step happens on the same edge.
      if (move_ev && state != DONE) begin
        if (cursor_o == CW'(NUM_CELLS - 1)) cursor_o <= '0;
        else                                cursor_o <= cursor_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_board_ctrl.sv
// tb/tb_memory_board_ctrl.sv - randomized scenario bench for memory_board_ctrl against a game-level model
module tb_memory_board_ctrl;

  localparam int N    = 16;
  localparam int CWID = 4;
  localparam int SHOW = 4;
  localparam int VW   = 4 + 2*N + 4 + 8 + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            move = 1'b0;
  logic            select = 1'b0;
  logic [N*CWID-1:0] card_i = '0;
  logic [3:0]      cursor_o;
  logic [2*N-1:0]  cell_state_o;
  logic [3:0]      pairs_o;
  logic [7:0]      attempts_o;
  logic            match_o, miss_o, done_o;
  logic [VW-1:0]   dut_vec;

  int passed = 0;
  int total  = 0;

  memory_board_ctrl #(.NUM_CELLS(N), .CARD_W(CWID), .SHOW_CYCLES(SHOW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .move(move), .select(select), .card_i(card_i),
    .cursor_o(cursor_o), .cell_state_o(cell_state_o), .pairs_o(pairs_o),
    .attempts_o(attempts_o), .match_o(match_o), .miss_o(miss_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {cursor_o, cell_state_o, pairs_o, attempts_o, match_o, miss_o, done_o};

  // Game-level reference: cells 0=hidden 1=revealed 2=matched, picks list, show countdown.
  int cards [N];
  int m_cells [N];
  int m_picks [$];
  int m_cursor, m_pairs, m_attempts, m_show;
  bit m_eq, m_match, m_miss, m_done, m_pm, m_ps;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_cells[i] = 0;
    m_picks.delete();
    m_cursor = 0; m_pairs = 0; m_attempts = 0; m_show = 0;
    m_eq = 0; m_match = 0; m_miss = 0; m_done = 0; m_pm = 0; m_ps = 0;
  endfunction

  function automatic void model_step(bit mv, bit sl);
    bit mev, sev, was_done;
    mev = mv && !m_pm;
    sev = sl && !m_ps;
    was_done = m_done;
    m_pm = mv; m_ps = sl;
    m_match = 0; m_miss = 0;
    if (!was_done) begin
      if (m_show > 0) begin
        m_show--;
        if (m_show == 0) begin
          if (m_eq) begin
            m_cells[m_picks[0]] = 2; m_cells[m_picks[1]] = 2;
            m_pairs++; m_match = 1;
            if (m_pairs == N/2) m_done = 1;
          end else begin
            m_cells[m_picks[0]] = 0; m_cells[m_picks[1]] = 0;
            m_miss = 1;
          end
          m_picks.delete();
        end
      end else if (sev && m_cells[m_cursor] == 0) begin
        m_cells[m_cursor] = 1;
        m_picks.push_back(m_cursor);
        if (m_picks.size() == 2) begin
          m_eq = (cards[m_picks[0]] == cards[m_picks[1]]);
          if (m_attempts < 255) m_attempts++;
          m_show = SHOW;
        end
      end
      if (mev) m_cursor = (m_cursor + 1) % N;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [2*N-1:0] cs;
    for (int i = 0; i < N; i++) cs[2*i +: 2] = 2'(m_cells[i]);
    return {4'(m_cursor), cs, 4'(m_pairs), 8'(m_attempts), m_match, m_miss, m_done};
  endfunction

  task automatic load_cards();
    for (int i = 0; i < N; i++) card_i[i*CWID +: CWID] = 4'(cards[i]);
  endtask

  task automatic tick(input bit mv, input bit sl);
    @(negedge clk);
    move = mv; select = sl;
    @(posedge clk);
    model_step(mv, sl);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; move = 0; select = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic goto(input int t);
    for (int k = 0; k < 2*N && m_cursor != t; k++) begin
      tick(1, 0); tick(0, 0);
    end
  endtask

  task automatic play_pair(input int a, input int b);
    goto(a); tick(0, 1);
    goto(b); tick(0, 1);
    repeat (SHOW) tick(0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec !== '0) $display("FAIL reset_zero: got %h want 0", dut_vec);
    else passed++;
    tick(0, 0);
    total++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
    else passed++;
  endtask

  task automatic test_move_wrap();
    for (int i = 0; i < 17; i++) begin
      tick(1, 0);
      total++;
      if (cursor_o !== 4'((i + 1) % N)) $display("FAIL move_step%0d: got %0d want %0d", i, cursor_o, (i + 1) % N);
      else passed++;
      tick(0, 0);
    end
    repeat (10) tick(1, 0);
    tick(0, 0);
    total++;
    if (cursor_o !== 4'd2) $display("FAIL move_held: got %0d want 2", cursor_o);
    else passed++;
  endtask

  task automatic test_match();
    do_reset();
    for (int i = 0; i < N; i++) cards[i] = 6 + (i - 4) / 2;
    cards[0] = 3; cards[1] = 3; cards[2] = 3; cards[3] = 5;
    load_cards();
    tick(0, 1); tick(1, 0); tick(0, 1);
    for (int i = 0; i < SHOW; i++) begin
      total++;
      if (cell_state_o[3:0] !== 4'b0101 || match_o !== 1'b0)
        $display("FAIL match_shown%0d: got cells=%b match=%b want 0101/0", i, cell_state_o[3:0], match_o);
      else passed++;
      tick(0, 0);
    end
    total++;
    if (cell_state_o[3:0] !== 4'b1010 || match_o !== 1'b1 || pairs_o !== 4'd1 || attempts_o !== 8'd1)
      $display("FAIL match_resolve: got cells=%b match=%b pairs=%0d att=%0d want 1010/1/1/1",
               cell_state_o[3:0], match_o, pairs_o, attempts_o);
    else passed++;
    tick(0, 0);
    total++;
    if (match_o !== 1'b0 || dut_vec !== exp_vec()) $display("FAIL match_after: got %h want %h", dut_vec, exp_vec());
    else passed++;
  endtask

  task automatic test_miss();
    tick(1, 0); tick(0, 1); tick(1, 0); tick(0, 1);
    for (int i = 0; i < SHOW; i++) begin
      total++;
      if (cell_state_o[7:4] !== 4'b0101 || miss_o !== 1'b0)
        $display("FAIL miss_shown%0d: got cells=%b miss=%b want 0101/0", i, cell_state_o[7:4], miss_o);
      else passed++;
      tick(0, 0);
    end
    total++;
    if (cell_state_o[7:4] !== 4'b0000 || miss_o !== 1'b1 || match_o !== 1'b0 || pairs_o !== 4'd1 || attempts_o !== 8'd2)
      $display("FAIL miss_resolve: got cells=%b miss=%b pairs=%0d att=%0d want 0000/1/1/2",
               cell_state_o[7:4], miss_o, pairs_o, attempts_o);
    else passed++;
  endtask

  task automatic test_ignored();
    goto(0); tick(0, 1); tick(0, 0);
    total++;
    if (cell_state_o[1:0] !== 2'b10 || attempts_o !== 8'd2 || dut_vec !== exp_vec())
      $display("FAIL sel_matched: got %h want %h", dut_vec, exp_vec());
    else passed++;
    goto(2); tick(0, 1); tick(0, 0); tick(0, 1);
    total++;
    if (cell_state_o[5:4] !== 2'b01 || attempts_o !== 8'd2 || dut_vec !== exp_vec())
      $display("FAIL sel_idx1: got %h want %h", dut_vec, exp_vec());
    else passed++;
    tick(1, 0); tick(0, 1);
    tick(0, 0); tick(0, 1); tick(1, 0);
    total++;
    if (cursor_o !== 4'd4 || cell_state_o[15:0] !== 16'h005a || attempts_o !== 8'd3)
      $display("FAIL show_inputs: got cur=%0d cells=%h att=%0d want 4/005a/3", cursor_o, cell_state_o[15:0], attempts_o);
    else passed++;
    tick(0, 0);
    total++;
    if (miss_o !== 1'b1 || dut_vec !== exp_vec()) $display("FAIL show_resolve: got %h want %h", dut_vec, exp_vec());
    else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    goto(5);
    tick(1, 1);
    total++;
    if (cell_state_o[11:10] !== 2'b01 || cursor_o !== 4'd6)
      $display("FAIL simul: got cell5=%b cur=%0d want 01/6", cell_state_o[11:10], cursor_o);
    else passed++;
  endtask

  task automatic test_full_game();
    int r, a, b, c, sw, t;
    int att_final;
    do_reset();
    r = $urandom_range(0, 15);
    for (int i = 0; i < N; i++) cards[i] = (i / 2) ^ r;
    for (int i = N - 1; i > 0; i--) begin
      sw = $urandom_range(0, i);
      t = cards[i]; cards[i] = cards[sw]; cards[sw] = t;
    end
    load_cards();
    for (int g = 0; g < N && m_pairs < N/2; g++) begin
      a = -1; b = -1; c = -1;
      for (int i = 0; i < N; i++) if (a < 0 && m_cells[i] == 0) a = i;
      for (int i = 0; i < N; i++) begin
        if (i != a && m_cells[i] == 0 && cards[i] == cards[a]) b = i;
        if (i != a && m_cells[i] == 0 && cards[i] != cards[a]) c = i;
      end
      if (c >= 0 && $urandom_range(0, 1) == 1) play_pair(a, c);
      play_pair(a, b);
      total++;
      if (dut_vec !== exp_vec()) $display("FAIL game_pair%0d: got %h want %h", g, dut_vec, exp_vec());
      else passed++;
    end
    total++;
    if (done_o !== 1'b1 || pairs_o !== 4'd8) $display("FAIL game_done: got done=%b pairs=%0d want 1/8", done_o, pairs_o);
    else passed++;
    att_final = m_attempts;
    repeat (20) tick(1'($urandom), 1'($urandom));
    total++;
    if (done_o !== 1'b1 || attempts_o !== 8'(att_final) || dut_vec !== exp_vec())
      $display("FAIL game_frozen: got %h want %h", dut_vec, exp_vec());
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) cards[i] = $urandom_range(0, 3);
    load_cards();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      total++;
      if (dut_vec !== exp_vec()) $display("FAIL random_cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    for (int i = 0; i < N; i++) cards[i] = i / 2;
    load_cards();
    play_pair(0, 1); play_pair(2, 3); play_pair(4, 5);
    goto(6); tick(0, 1); tick(1, 0); tick(0, 1); tick(0, 0);
    total++;
    if (pairs_o !== 4'd3 || cell_state_o[15:12] !== 4'b0101) $display("FAIL pre_reset: got pairs=%0d cells=%b want 3/0101", pairs_o, cell_state_o[15:12]);
    else passed++;
    #2 rst = 1;
    model_reset();
    #1;
    total++;
    if (dut_vec !== '0) $display("FAIL mid_show_reset: got %h want 0", dut_vec);
    else passed++;
    @(negedge clk);
    rst = 0;
    play_pair(0, 1);
    total++;
    if (pairs_o !== 4'd1 || cell_state_o[1:0] !== 2'b10 || dut_vec !== exp_vec())
      $display("FAIL post_reset_play: got %h want %h", dut_vec, exp_vec());
    else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move_wrap();
    test_match();
    test_miss();
    test_ignored();
    test_simultaneous();
    test_full_game();
    test_random();
    test_reset_mid_show();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/memory_board_ctrl.md
Name: memory_board_ctrl

Overview:
- Parametrised cursor/selection controller for the card-matching game board. Successor to the fixed 16-cell move block.
- Steps a cursor over NUM_CELLS cells on `move`. Reveals cards on `select` and compares each pair after a timed show window.
- Tracks per-cell state (hidden/revealed/matched), pairs found and attempts, and flags game completion.
- Sits between the debounced button inputs and the board display/score logic.

Parameters:
- NUM_CELLS, 16, number of board cells; must be even and >= 2 (elaboration-time assertion).
- CARD_W, 4, bit width of each card value.
- SHOW_CYCLES, 4, clock cycles a revealed pair stays visible before resolution; must be >= 1.
- CNT_W, 8, width of the attempts counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- move  in  1  advance-cursor button level; synchronous to clk, debounced upstream
- select  in  1  reveal-card button level; synchronous to clk, debounced upstream
- card_i  in  NUM_CELLS*CARD_W  card values; cell i occupies bits [i*CARD_W +: CARD_W]
- cursor_o  out  $clog2(NUM_CELLS)  current cursor cell index
- cell_state_o  out  2*NUM_CELLS  per-cell state; cell i occupies bits [2i +: 2]
- pairs_o  out  $clog2(NUM_CELLS/2+1)  matched pairs found
- attempts_o  out  CNT_W  completed pair attempts
- match_o  out  1  one-cycle pulse when a pair resolves as a match
- miss_o  out  1  one-cycle pulse when a pair resolves as a mismatch
- done_o  out  1  high once all pairs are matched

Behaviour:
- Reset (async assert, applied at any time including mid-SHOW):
  - cursor_o=0; all cells HIDDEN; pairs_o=0; attempts_o=0; match_o=miss_o=done_o=0.
  - FSM goes to PICK1; show timer=0; edge-detect registers=0.
- Edge detection:
  - move_q/select_q register the previous input level. Event = level & ~prev.
  - A held button produces exactly one event. An event takes effect at the first clk edge where the level is sampled high, so outputs change 1 cycle after the rising input.
- Cursor:
  - Each move event increments cursor_o; NUM_CELLS-1 wraps to 0.
  - Move is accepted in PICK1, PICK2 and SHOW; ignored in DONE.
- FSM states: PICK1, PICK2, SHOW, DONE.
  - PICK1: a select event on a HIDDEN cell sets it REVEALED, latches idx1 <= cursor_o, and moves to PICK2.
  - PICK2: a select event on a HIDDEN cell does all of the following, then moves to SHOW:
    - sets the cell REVEALED and latches idx2;
    - registers eq = (card[idx1] == card[idx2]), sampling card_i in this cycle;
    - increments attempts_o, saturating at 2^CNT_W-1;
    - loads timer = SHOW_CYCLES-1.
  - SHOW: select is ignored. Timer decrements each cycle. In the cycle timer==0:
    - eq=1: both cells set MATCHED, pairs_o+1, match_o pulses.
    - eq=0: both cells set HIDDEN, miss_o pulses.
    - Next state is DONE if the new pairs_o == NUM_CELLS/2, otherwise PICK1.
  - Both cells stay REVEALED for exactly SHOW_CYCLES cycles.
  - DONE: done_o=1; all inputs ignored until rst.
- Select on a REVEALED or MATCHED cell: no state change, no counter change.
- Simultaneous move and select events in one cycle: select applies to the pre-move cursor, then the cursor advances.
- match_o and miss_o are never high together and never high outside the SHOW resolution cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package memory_board_pkg:
  - cell_state_t enum: HIDDEN=2'b00, REVEALED=2'b01, MATCHED=2'b10.
  - board_fsm_t enum: PICK1, PICK2, SHOW, DONE.
- Sub-module rise_detect (clk, rst, level_i, pulse_o), instantiated once for move and once for select.

Test Plan:
- Reset, then 17 single-cycle move pulses -> cursor_o runs 0..15 then 0. Move held high for 10 cycles -> exactly one step.
- card0=card1=3: select@0, move, select@1 -> cells 0 and 1 REVEALED for 4 cycles, then MATCHED (state 2'b10); match_o high for 1 cycle; pairs_o=1; attempts_o=1.
- card2=3, card3=5: select@2, move, select@3 -> after 4 cycles both cells HIDDEN; miss_o high for 1 cycle; pairs_o unchanged; attempts_o +1.
- Select on a MATCHED cell, select on the idx1 cell in PICK2, and select during SHOW -> no cell_state_o or counter change. Move during SHOW -> cursor still advances.
- Move and select events in the same cycle at cursor 5 -> cell 5 REVEALED, cursor_o=6. Play all 8 pairs -> done_o=1 after the last SHOW; further inputs cause no change.
- Assert rst during SHOW with two cells REVEALED and pairs_o=3 -> all outputs immediately at reset values; play resumes from PICK1 after release.
